// File: rtl/pmodjstk_spi_responder.sv
// pmodjstk_spi_responder: PmodJSTK-compatible SPI slave serving joystick data and capturing LED commands
module pmodjstk_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [5:0] CMD_PREFIX  = 6'b100000
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic       sck,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [2:0] btn_in,
  output logic       ld1,
  output logic       ld2,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ACTIVE, OVERRUN} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr;
  logic [SYNC_STAGES:0] settle;
  logic sck_d, cs_d, armed;
  logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall;
  logic [39:0] snap, tx, rx;
  logic [5:0] bit_cnt;
  logic [3:0] ovr_cnt;
  assign sck_s    = sck_sr[SYNC_STAGES-1];
  assign cs_s     = cs_sr[SYNC_STAGES-1];
  assign mosi_s   = mosi_sr[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = armed & ~cs_s & cs_d;
  assign snap     = {x_in[7:0], 6'b0, x_in[9:8], y_in[7:0], 6'b0, y_in[9:8], 5'b0, btn_in};
  assign busy     = (state != IDLE);
  // Synchronize SPI pins; a frame may only start after cs is seen truly high once the chain has flushed
  always_ff @(posedge clk50M) begin
    if (reset) begin
      sck_sr  <= '0;
      cs_sr   <= '1;
      mosi_sr <= '0;
      sck_d   <= 1'b0;
      cs_d    <= 1'b1;
      settle  <= '0;
      armed   <= 1'b0;
    end else begin
      sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sck_d   <= sck_s;
      cs_d    <= cs_s;
      settle  <= {settle[SYNC_STAGES-1:0], 1'b1};
      armed   <= armed | (settle[SYNC_STAGES] & cs_s);
    end
  end
  // Frame FSM: shift out snapshot on sck fall, shift in mosi on sck rise, judge the frame at cs rise
  always_ff @(posedge clk50M) begin
    if (reset) begin
      state      <= IDLE;
      miso       <= 1'b0;
      ld1        <= 1'b0;
      ld2        <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      bit_cnt    <= '0;
      ovr_cnt    <= '0;
      tx         <= '0;
      rx         <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (state != IDLE && cs_rise) begin
        state <= IDLE;
        miso  <= 1'b0;
        if (state == ACTIVE && bit_cnt == 6'd40) begin
          frame_done <= 1'b1;
          if (rx[39:34] == CMD_PREFIX) begin
            ld1 <= rx[32];
            ld2 <= rx[33];
          end
        end else begin
          frame_err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            miso <= 1'b0;
            if (cs_fall) begin
              miso    <= snap[39];
              tx      <= {snap[38:0], 1'b0};
              rx      <= '0;
              bit_cnt <= '0;
              ovr_cnt <= '0;
              state   <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (sck_rise) begin
              if (bit_cnt == 6'd40) begin
                state   <= OVERRUN;
                miso    <= 1'b0;
                ovr_cnt <= 4'd1;
              end else begin
                rx      <= {rx[38:0], mosi_s};
                bit_cnt <= bit_cnt + 6'd1;
              end
            end else if (sck_fall && bit_cnt != 6'd0) begin
              miso <= tx[39];
              tx   <= {tx[38:0], 1'b0};
            end
          end
          OVERRUN: begin
            miso <= 1'b0;
            if ((sck_rise || sck_fall) && ovr_cnt != 4'hF) ovr_cnt <= ovr_cnt + 4'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pmodjstk_spi_responder.sv
// tb_pmodjstk_spi_responder: directed SPI-master bench for the joystick responder
module tb_pmodjstk_spi_responder;
  localparam int HALF = 25;
  logic clk50M = 1'b0, reset = 1'b1, sck = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic [9:0] x_in = 10'h2A5, y_in = 10'h13C;
  logic [2:0] btn_in = 3'b101;
  logic miso, ld1, ld2, frame_done, frame_err, busy;
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int d0, e0, dn, en;
  logic [43:0] mb;
  logic busy_mid;
  pmodjstk_spi_responder dut (
    .clk50M(clk50M), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .x_in(x_in), .y_in(y_in), .btn_in(btn_in), .ld1(ld1), .ld2(ld2),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );
  always #10 clk50M = ~clk50M;
  always @(negedge clk50M) begin
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (frame_done && frame_err) both_cnt++;
  end
  task automatic spi_frame(input logic [39:0] cmd, input int nbits, input int chg_bit, input int rst_bit);
    logic [39:0] sh;
    sh = cmd;
    d0 = done_cnt;
    e0 = err_cnt;
    mb = '0;
    busy_mid = 1'b0;
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = sh[39];
      sh = sh << 1;
      if (i == chg_bit) x_in = 10'h3FF;
      if (i == rst_bit) begin
        reset = 1'b1;
        repeat (3) @(negedge clk50M);
        reset = 1'b0;
      end
      repeat (HALF) @(negedge clk50M);
      mb = {mb[42:0], miso};
      if (i == 5) busy_mid = busy;
      sck = 1'b1;
      repeat (HALF) @(negedge clk50M);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk50M);
    cs = 1'b1;
    repeat (HALF) @(negedge clk50M);
    dn = done_cnt - d0;
    en = err_cnt - e0;
  endtask
  task automatic test_reset();
    repeat (5) @(negedge clk50M);
    reset = 1'b0;
    repeat (10) @(negedge clk50M);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
    checks++; if ({ld2, ld1} !== 2'b00) begin errors++; $display("FAIL reset_leds: got %b expected 00", {ld2, ld1}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({frame_done, frame_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {frame_done, frame_err}); end
  endtask
  task automatic test_frame_led_both();
    spi_frame({8'h83, 32'h0}, 40, -1, -1);
    checks++; if (mb[39:0] !== 40'hA5023C0105) begin errors++; $display("FAIL f1_miso: got %h expected A5023C0105", mb[39:0]); end
    checks++; if (dn !== 1 || en !== 0) begin errors++; $display("FAIL f1_pulses: got done=%0d err=%0d expected 1/0", dn, en); end
    checks++; if ({ld2, ld1} !== 2'b11) begin errors++; $display("FAIL f1_leds: got %b expected 11", {ld2, ld1}); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL f1_busy_mid: got %b expected 1", busy_mid); end
    checks++; if (busy !== 1'b0 || miso !== 1'b0) begin errors++; $display("FAIL f1_idle: got busy=%b miso=%b expected 0/0", busy, miso); end
  endtask
  task automatic test_frame_led1();
    spi_frame({8'h81, 32'h0}, 40, -1, -1);
    checks++; if ({ld2, ld1} !== 2'b01) begin errors++; $display("FAIL f2_leds: got %b expected 01", {ld2, ld1}); end
    checks++; if (dn !== 1 || en !== 0) begin errors++; $display("FAIL f2_pulses: got done=%0d err=%0d expected 1/0", dn, en); end
  endtask
  task automatic test_snapshot();
    spi_frame({8'h82, 32'h0}, 40, 1, -1);
    checks++; if (mb[39:0] !== 40'hA5023C0105) begin errors++; $display("FAIL snap_miso: got %h expected A5023C0105", mb[39:0]); end
    checks++; if ({ld2, ld1} !== 2'b10) begin errors++; $display("FAIL snap_leds: got %b expected 10", {ld2, ld1}); end
    checks++; if (dn !== 1 || en !== 0) begin errors++; $display("FAIL snap_pulses: got done=%0d err=%0d expected 1/0", dn, en); end
  endtask
  task automatic test_abort();
    spi_frame({8'h83, 32'h0}, 17, -1, -1);
    checks++; if (mb[16:0] !== 17'h1FE06) begin errors++; $display("FAIL abort_miso: got %h expected 1fe06", mb[16:0]); end
    checks++; if (dn !== 0 || en !== 1) begin errors++; $display("FAIL abort_pulses: got done=%0d err=%0d expected 0/1", dn, en); end
    checks++; if ({ld2, ld1} !== 2'b10) begin errors++; $display("FAIL abort_leds: got %b expected 10", {ld2, ld1}); end
    checks++; if (busy !== 1'b0 || miso !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b miso=%b expected 0/0", busy, miso); end
  endtask
  task automatic test_prefix_mismatch();
    y_in = 10'h0C8;
    btn_in = 3'b010;
    spi_frame({8'h43, 32'h0}, 40, -1, -1);
    checks++; if (mb[39:0] !== 40'hFF03C80002) begin errors++; $display("FAIL pfx_miso: got %h expected FF03C80002", mb[39:0]); end
    checks++; if (dn !== 1 || en !== 0) begin errors++; $display("FAIL pfx_pulses: got done=%0d err=%0d expected 1/0", dn, en); end
    checks++; if ({ld2, ld1} !== 2'b10) begin errors++; $display("FAIL pfx_leds: got %b expected 10", {ld2, ld1}); end
  endtask
  task automatic test_overrun();
    spi_frame({8'h81, 32'h0}, 44, -1, -1);
    checks++; if (mb[43:4] !== 40'hFF03C80002) begin errors++; $display("FAIL ovr_miso: got %h expected FF03C80002", mb[43:4]); end
    checks++; if (mb[3:0] !== 4'h0) begin errors++; $display("FAIL ovr_tail: got %b expected 0000", mb[3:0]); end
    checks++; if (dn !== 0 || en !== 1) begin errors++; $display("FAIL ovr_pulses: got done=%0d err=%0d expected 0/1", dn, en); end
    checks++; if ({ld2, ld1} !== 2'b10) begin errors++; $display("FAIL ovr_leds: got %b expected 10", {ld2, ld1}); end
  endtask
  task automatic test_reset_mid_frame();
    spi_frame({8'h81, 32'h0}, 30, -1, 20);
    checks++; if (mb[9:0] !== 10'h000) begin errors++; $display("FAIL rstmid_miso: got %b expected 0", mb[9:0]); end
    checks++; if (dn !== 0 || en !== 0) begin errors++; $display("FAIL rstmid_pulses: got done=%0d err=%0d expected 0/0", dn, en); end
    checks++; if ({ld2, ld1} !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: got leds=%b busy=%b expected 00/0", {ld2, ld1}, busy); end
  endtask
  task automatic test_back_to_back();
    x_in = 10'h155;
    y_in = 10'h2AA;
    btn_in = 3'b111;
    spi_frame({8'h83, 32'h0}, 40, -1, -1);
    checks++; if (mb[39:0] !== 40'h5501AA0207) begin errors++; $display("FAIL b2b_miso: got %h expected 5501AA0207", mb[39:0]); end
    checks++; if (dn !== 1 || en !== 0) begin errors++; $display("FAIL b2b_pulses: got done=%0d err=%0d expected 1/0", dn, en); end
    checks++; if ({ld2, ld1} !== 2'b11) begin errors++; $display("FAIL b2b_leds: got %b expected 11", {ld2, ld1}); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", both_cnt); end
  endtask
  initial begin
    test_reset();
    test_frame_led_both();
    test_frame_led1();
    test_snapshot();
    test_abort();
    test_prefix_mismatch();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
